// File: rtl/counter_ctrl_unit_if.sv
// Control/status bundle between the 0..9 counter controller, its buttons and its datapath.
// The master side drives start/stop/ALt10; the controller (slave) drives the strobes and status.
interface counter_ctrl_unit_if;
  logic       start;
  logic       stop;
  logic       ALt10;
  logic       ASrcMuxSel;
  logic       ALoad;
  logic       OutBufSel;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;
  logic [2:0] state_o;

  modport master (
    output start, stop, ALt10,
    input  ASrcMuxSel, ALoad, OutBufSel, busy, done, pass_cnt, state_o
  );

  modport slave (
    input  start, stop, ALt10,
    output ASrcMuxSel, ALoad, OutBufSel, busy, done, pass_cnt, state_o
  );
endinterface

// File: rtl/counter_ctrl_unit.sv
// Sequencer for the A=0..9 counter datapath: prescaled FSM steps, stop abort, optional auto-loop, pass count.
// One FSM step per TICK_DIV clocks, strobes are 1-clk; no backpressure, stop forces IDLE at the next edge.
module counter_ctrl_unit #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned LOOP     = 0
) (
  input logic               clk,
  input logic               reset,
  counter_ctrl_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    CMP   = 3'd2,
    OUT   = 3'd3,
    INC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int unsigned     CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(TICK_DIV - 1);
  localparam bit              LOOP_EN = (LOOP != 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pass_q, pass_d;
  logic          aload_q, aload_d;
  logic          obs_q, obs_d;
  logic          asrc_q, asrc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          running, tick, start_acc;
  logic          run_n, tick_n;

  always_comb begin
    running   = (state_q inside {CLEAR, CMP, OUT, INC}) || (LOOP_EN && state_q == DONE);
    tick      = running && (cnt_q == LAST);
    start_acc = bus.start && (state_q == IDLE || state_q == DONE);

    state_d = state_q;
    pass_d  = pass_q;
    cnt_d   = (running && !tick) ? cnt_q + 1'b1 : '0;

    case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: if (tick) state_d = CMP;
      CMP: begin
        if (tick) begin
          if (bus.ALt10) begin
            state_d = OUT;
          end else begin
            state_d = DONE;
            pass_d  = pass_q + 8'd1;
          end
        end
      end
      OUT:   if (tick) state_d = INC;
      INC:   if (tick) state_d = CMP;
      DONE: begin
        if (bus.start)             state_d = CLEAR;
        else if (LOOP_EN && tick)  state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase

    if (start_acc) cnt_d = '0;

    // stop overrides every transition, including the CMP->DONE pass increment
    if (bus.stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pass_d  = pass_q;
    end

    // Outputs are registered: evaluate the Moore decode on the next state/count.
    run_n   = (state_d inside {CLEAR, CMP, OUT, INC}) || (LOOP_EN && state_d == DONE);
    tick_n  = run_n && (cnt_d == LAST);
    aload_d = tick_n && (state_d == CLEAR || state_d == INC);
    obs_d   = tick_n && (state_d == OUT);
    asrc_d  = (state_d == INC);
    busy_d  = (state_d inside {CLEAR, CMP, OUT, INC});
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      aload_q <= 1'b0;
      obs_q   <= 1'b0;
      asrc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      aload_q <= aload_d;
      obs_q   <= obs_d;
      asrc_q  <= asrc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A stop arriving during a strobe cycle must kill that strobe immediately.
  assign bus.ALoad      = aload_q && !bus.stop;
  assign bus.OutBufSel  = obs_q && !bus.stop;
  assign bus.ASrcMuxSel = asrc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass_cnt   = pass_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Scoreboard bench: three controllers (TICK_DIV=1, TICK_DIV=4, LOOP=1) each driving a behavioural 0..9 datapath.
module tb_counter_ctrl_unit;

  typedef struct {
    int kind;   // 0: ALoad (val = ASrcMuxSel), 1: OutBufSel (val = A loaded), 2: done rise (val = pass_cnt)
    int at;
    int val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, start_v, stop_v;
  logic [2:0] asrc_v, aload_v, obs_v, busy_v, done_v;
  logic [7:0] pass_v [3];
  logic [2:0] st_v [3];
  logic [3:0] a_r [3]   = '{default: 4'd0};
  logic [3:0] out_r [3] = '{default: 4'd0};
  logic [2:0] done_prev = 3'b000;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  int  pass_m [3];
  ev_t exp_q [3][$];

  genvar g;
  for (g = 0; g < 3; g++) begin : gen_u
    counter_ctrl_unit_if ifc ();
    assign ifc.start  = start_v[g];
    assign ifc.stop   = stop_v[g];
    assign ifc.ALt10  = (a_r[g] < 4'd10);
    assign asrc_v[g]  = ifc.ASrcMuxSel;
    assign aload_v[g] = ifc.ALoad;
    assign obs_v[g]   = ifc.OutBufSel;
    assign busy_v[g]  = ifc.busy;
    assign done_v[g]  = ifc.done;
    assign pass_v[g]  = ifc.pass_cnt;
    assign st_v[g]    = ifc.state_o;

    counter_ctrl_unit #(
      .TICK_DIV((g == 1) ? 4 : 1),
      .LOOP    ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk  (clk),
      .reset(rst_v[g]),
      .bus  (ifc.slave)
    );
  end

  function automatic int n_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every step lasts n cycles starting at t0; strobes fall on the last cycle of their step.
  task automatic push_run(input int i, input int t0, input int n, input int pass);
    ev_t e;
    e = '{0, t0 + n - 1, 0};
    exp_q[i].push_back(e);
    for (int v = 0; v < 10; v++) begin
      e = '{1, t0 + (3 * v + 2) * n + n - 1, v};
      exp_q[i].push_back(e);
      e = '{0, t0 + (3 * v + 3) * n + n - 1, 1};
      exp_q[i].push_back(e);
    end
    e = '{2, t0 + 32 * n, pass & 255};
    exp_q[i].push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Datapath: A <= 0 or A+1 on ALoad, out <= A on OutBufSel.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (aload_v[i]) a_r[i] <= asrc_v[i] ? a_r[i] + 4'd1 : 4'd0;
      if (obs_v[i])   out_r[i] <= a_r[i];
    end
  end

  // Monitor: every strobe or done rise must match the head of that instance's queue.
  always @(negedge clk) begin
    ev_t  e;
    int   k;
    int   act;
    logic rise;
    for (int i = 0; i < 3; i++) begin
      rise = done_v[i] & ~done_prev[i];
      if (aload_v[i] | obs_v[i] | rise) begin
        k   = aload_v[i] ? 0 : (obs_v[i] ? 1 : 2);
        act = (k == 0) ? int'(asrc_v[i]) : ((k == 1) ? int'(a_r[i]) : int'(pass_v[i]));
        chk("evt_overlap", int'(aload_v[i]) + int'(obs_v[i]) + int'(rise), 1);
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: inst %0d kind %0d at cycle %0d, none required", i, k, cyc);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("evt_kind[%0d]", i), k, e.kind);
          chk($sformatf("evt_cycle[%0d]", i), cyc, e.at);
          chk($sformatf("evt_value[%0d]", i), act, e.val);
          if (k == 2) chk($sformatf("busy_at_done[%0d]", i), int'(busy_v[i]), 0);
        end
      end
      done_prev[i] <= done_v[i];
    end
  end

  task automatic start_run(input int i, input bit counts);
    start_v[i] = 1'b1;
    if (counts) pass_m[i]++;
    push_run(i, cyc + 1, n_of(i), pass_m[i]);
    step(1);
    start_v[i] = 1'b0;
  endtask

  initial begin
    int t0;
    int found;
    rst_v   = 3'b000;
    start_v = 3'b000;
    stop_v  = 3'b000;
    for (int i = 0; i < 3; i++) pass_m[i] = 0;
    step(3);

    for (int i = 0; i < 3; i++) begin
      chk("rst_state", int'(st_v[i]), 0);
      chk("rst_outs", int'({asrc_v[i], aload_v[i], obs_v[i], busy_v[i], done_v[i]}), 0);
      chk("rst_pass", int'(pass_v[i]), 0);
    end
    rst_v = 3'b111;
    step(2);

    // Full runs at TICK_DIV=1 and TICK_DIV=4 side by side.
    start_v[0] = 1'b1;
    start_run(1, 1'b1);
    pass_m[0]++;
    push_run(0, cyc, 1, pass_m[0]);
    start_v[0] = 1'b0;
    step(140);
    for (int i = 0; i < 2; i++) begin
      chk("run_out", int'(out_r[i]), 9);
      chk("run_pass", int'(pass_v[i]), pass_m[i]);
      chk("run_done", int'(done_v[i]), 1);
    end

    // start held high from DONE through most of a run: only the first cycle matters.
    start_v[0] = 1'b1;
    pass_m[0]++;
    push_run(0, cyc + 1, 1, pass_m[0]);
    step(1);
    chk("done_start_clear", int'(st_v[0]), 1);
    step(19);
    start_v[0] = 1'b0;
    step(20);
    chk("held_pass", int'(pass_v[0]), pass_m[0]);
    chk("held_state", int'(st_v[0]), 5);

    // Abort while out shows 5.
    start_run(0, 1'b0);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (out_r[0] == 4'd5) found = 1;
      else step(1);
    end
    chk("stop_reach5", found, 1);
    stop_v[0] = 1'b1;
    exp_q[0].delete();
    step(1);
    stop_v[0] = 1'b0;
    chk("stop_state", int'(st_v[0]), 0);
    chk("stop_busy", int'(busy_v[0]), 0);
    step(10);
    chk("stop_out_kept", int'(out_r[0]), 5);
    chk("stop_pass_kept", int'(pass_v[0]), pass_m[0]);
    start_run(0, 1'b1);
    step(40);
    chk("restart_out", int'(out_r[0]), 9);
    chk("restart_pass", int'(pass_v[0]), pass_m[0]);

    // Leave DONE via stop, then start+stop together in IDLE.
    stop_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    stop_v[0]  = 1'b0;
    chk("startstop_state", int'(st_v[0]), 0);
    step(5);
    chk("startstop_idle", int'(st_v[0]), 0);

    // Async reset in the middle of an INC step.
    start_run(1, 1'b0);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (st_v[1] == 3'd4) found = 1;
      else step(1);
    end
    chk("reach_inc", found, 1);
    #2;
    rst_v[1] = 1'b0;
    exp_q[1].delete();
    pass_m[1] = 0;
    #1;
    chk("arst_state", int'(st_v[1]), 0);
    chk("arst_outs", int'({asrc_v[1], aload_v[1], obs_v[1], busy_v[1], done_v[1]}), 0);
    chk("arst_pass", int'(pass_v[1]), 0);
    step(1);
    rst_v[1] = 1'b1;

    // Auto-loop: 256 back-to-back runs, period 33 clocks, pass_cnt wraps to 0.
    t0 = cyc + 1;
    start_v[2] = 1'b1;
    for (int k = 0; k < 256; k++) push_run(2, t0 + 33 * k, 1, k + 1);
    step(1);
    start_v[2] = 1'b0;
    while (cyc < t0 + 2 * 33 + 32) step(1);
    chk("loop_pass3", int'(pass_v[2]), 3);
    chk("loop_done3", int'(done_v[2]), 1);
    while (cyc < t0 + 255 * 33 + 32) step(1);
    chk("loop_wrap", int'(pass_v[2]), 0);
    chk("loop_done_last", int'(done_v[2]), 1);
    stop_v[2] = 1'b1;
    step(1);
    stop_v[2] = 1'b0;
    chk("loop_stop_state", int'(st_v[2]), 0);

    step(5);
    for (int i = 0; i < 3; i++) chk("events_left", exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
